// File: rtl/alu_serial.sv
// Digit-serial ALU: processes DIGIT bits per clock over WIDTH/DIGIT cycles.
// Keeps persistent C/Z/N/V flags so ADC/SBC can chain multi-word arithmetic.
module alu_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n,
   output logic             flag_v
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_ADC = 3'b001;
   localparam logic [2:0] OP_SUB = 3'b010;
   localparam logic [2:0] OP_SBC = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_CMP = 3'b111;

   logic [0:0]       state_r;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] acc_r;
   logic [WIDTH-1:0] result_r;
   logic [2:0]       op_r;
   logic             carry_r;
   logic             done_r;
   logic             c_r;
   logic             z_r;
   logic             n_r;
   logic             v_r;

   logic [DIGIT-1:0] a_dig_s;
   logic [DIGIT-1:0] b_dig_s;
   logic [DIGIT-1:0] dig_s;
   logic [DIGIT:0]   sum_s;
   logic [WIDTH-1:0] dig_ext_s;
   logic [WIDTH-1:0] acc_next_s;
   logic             arith_s;
   logic             last_s;
   logic             v_next_s;
   logic             sub_s;
   logic             cin_s;

   // Digit datapath: one DIGIT-wide slice of add or logic op per cycle
   always_comb begin
      a_dig_s   = a_r[DIGIT-1:0];
      b_dig_s   = b_r[DIGIT-1:0];
      sum_s     = {1'b0, a_dig_s} + {1'b0, b_dig_s} + {{DIGIT{1'b0}}, carry_r};
      arith_s   = (op_r[2] == 1'b0) || (op_r == OP_CMP);
      case (op_r)
         OP_AND:  dig_s = a_dig_s & b_dig_s;
         OP_OR:   dig_s = a_dig_s | b_dig_s;
         OP_XOR:  dig_s = a_dig_s ^ b_dig_s;
         default: dig_s = sum_s[DIGIT-1:0];
      endcase
      dig_ext_s = {WIDTH{1'b0}};
      dig_ext_s[DIGIT-1:0] = dig_s;
      // New digit enters at the top so the LSB digit ends up at bit 0 after NDIG shifts
      acc_next_s = (dig_ext_s << (WIDTH - DIGIT)) | (acc_r >> DIGIT);
      last_s     = (cnt_r == CW'(NDIG - 1));
      if (arith_s) begin
         v_next_s = (a_dig_s[DIGIT-1] == b_dig_s[DIGIT-1]) &&
                    (acc_next_s[WIDTH-1] != a_dig_s[DIGIT-1]);
      end else begin
         v_next_s = 1'b0;
      end
   end

   // Accept decode: operand inversion and carry-in chosen from the incoming opcode
   always_comb begin
      sub_s = (op == OP_SUB) || (op == OP_SBC) || (op == OP_CMP);
      case (op)
         OP_ADD:  cin_s = 1'b0;
         OP_ADC:  cin_s = c_r;
         OP_SUB:  cin_s = 1'b1;
         OP_SBC:  cin_s = c_r;
         OP_CMP:  cin_s = 1'b1;
         default: cin_s = 1'b0;
      endcase
   end

   // Control FSM, operand shifters, result and flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= {CW{1'b0}};
         a_r      <= {WIDTH{1'b0}};
         b_r      <= {WIDTH{1'b0}};
         acc_r    <= {WIDTH{1'b0}};
         result_r <= {WIDTH{1'b0}};
         op_r     <= 3'b000;
         carry_r  <= 1'b0;
         done_r   <= 1'b0;
         c_r      <= 1'b0;
         z_r      <= 1'b0;
         n_r      <= 1'b0;
         v_r      <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (start) begin
                  a_r     <= a;
                  b_r     <= sub_s ? ~b : b;
                  op_r    <= op;
                  carry_r <= cin_s;
                  cnt_r   <= {CW{1'b0}};
                  state_r <= RUN;
               end
            end
            RUN: begin
               a_r     <= a_r >> DIGIT;
               b_r     <= b_r >> DIGIT;
               carry_r <= sum_s[DIGIT];
               acc_r   <= acc_next_s;
               cnt_r   <= cnt_r + CW'(1);
               if (last_s) begin
                  state_r <= IDLE;
                  done_r  <= 1'b1;
                  if (op_r != OP_CMP) begin
                     result_r <= acc_next_s;
                  end
                  z_r <= (acc_next_s == {WIDTH{1'b0}});
                  n_r <= acc_next_s[WIDTH-1];
                  v_r <= v_next_s;
                  if (arith_s) begin
                     c_r <= sum_s[DIGIT];
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   assign busy   = (state_r == RUN);
   assign done   = done_r;
   assign result = result_r;
   assign flag_c = c_r;
   assign flag_z = z_r;
   assign flag_n = n_r;
   assign flag_v = v_r;

endmodule

// File: doc/alu_serial.md
Name: alu_serial

Overview:
Parametrised digit-serial ALU for the 8-bit datapath, succeeding the purely combinational ripple adder. It processes DIGIT bits per clock over WIDTH/DIGIT cycles and supports add/subtract with and without carry-in, logic ops and compare. It keeps a registered flag set (C, Z, N, V) that persists between operations for multi-word arithmetic. It sits between the A/B registers and the bus, and is controlled by the sequencer through a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of DIGIT
DIGIT, 4, bits processed per cycle; 1 <= DIGIT <= WIDTH; NDIG = WIDTH/DIGIT cycles per op

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
op  in  3  opcode: 000 ADD, 001 ADC, 010 SUB, 011 SBC, 100 AND, 101 OR, 110 XOR, 111 CMP
a  in  WIDTH  operand A, latched on accept
b  in  WIDTH  operand B, latched on accept
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when result/flags update
result  out  WIDTH  registered result
flag_c  out  1  carry flag (for subtract: 1 = no borrow)
flag_z  out  1  zero flag
flag_n  out  1  negative flag (msb of computed value)
flag_v  out  1  signed-overflow flag

Behaviour:
- Reset (async assert, sync-release use assumed by system): state IDLE; result=0, all flags=0, busy=0, done=0; digit counter=0; latched operands=0. Reset during RUN abandons the op without updating result or flags.
- FSM states: IDLE, RUN.
- IDLE: start=1 at edge k -> latch a, b, op; latch carry-in: ADD=0, SUB=1, ADC/SBC=flag_c, logic ops don't care; counter=0; go to RUN; busy=1 from edge k.
- RUN: each edge processes digit[counter] (LSB digit first) into a shift/partial register and propagates internal carry; at edge k+NDIG the final digit completes: go to IDLE, busy=0, done=1 for exactly one cycle, and result/flags update at that same edge. Latency is NDIG cycles from accept to done.
- start while busy=1 is ignored (not queued). start during the done cycle is accepted, because busy=0 then; back-to-back throughput is one op per NDIG+1 cycles... (start at edge k+NDIG+1).
- Arithmetic: ADD/ADC compute a+b+cin. SUB/SBC/CMP compute a+~b+cin. Result is WIDTH bits mod 2^WIDTH. flag_c = carry out of the msb. flag_v = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted b for subtract ops.
- Logic ops: bitwise; flag_c unchanged; flag_v=0.
- All ops: flag_z = (computed value == 0); flag_n = msb of computed value.
- CMP: updates flags only; result holds its previous value.
- Flags and result stay stable between done pulses; inputs a/b/op may change freely during RUN without effect.

Test Plan:
- WIDTH=8, DIGIT=4: ADD a=0x03 b=0x04 start at edge k -> busy edges k..k+2, done pulse after edge k+2, result=0x07, C=0 Z=0 N=0 V=0.
- ADD 0xFF+0x01 -> result=0x00, C=1, Z=1. Then ADC 0x00+0x00 -> result=0x01, C=0, Z=0. This checks carry chaining.
- SUB 0x0D-0x01 -> 0x0C, C=1. SUB 0x01-0x02 -> 0xFF, C=0, N=1. ADD 0x7F+0x01 -> 0x80, V=1, N=1.
- Set result=0x0C, then CMP 0x05,0x05 -> result stays 0x0C, Z=1, C=1. Then AND 0xF0,0x0F -> 0x00, Z=1, C unchanged, V=0.
- start pulsed again mid-RUN with different operands -> ignored, original result delivered. Assert rst_n=0 mid-RUN -> busy=0, done=0, result=0, flags=0 immediately, no done pulse follows.
- WIDTH=16, DIGIT=1: ADD 0x8000+0x8000 -> done exactly 16 cycles after accept, result=0x0000, C=1, V=1, Z=1.
